// File: rtl/mc_seq_ctrl_pkg.sv
// Shared constants and types for the multicycle control sequencer:
// opcodes, step numbers, FSM states, IR field positions and the strobe bundle.
package mc_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RRF = 3'd7;

  localparam logic [3:0] T0    = 4'd0;
  localparam logic [3:0] T1    = 4'd1;
  localparam logic [3:0] T2    = 4'd2;
  localparam logic [3:0] T3    = 4'd3;
  localparam logic [3:0] T4    = 4'd4;
  localparam logic [3:0] T5    = 4'd5;
  localparam logic [3:0] T6    = 4'd6;
  localparam logic [3:0] T_ILL = 4'd15;

  localparam int IR_I     = 15;
  localparam int IR_OP_HI = 14;
  localparam int IR_OP_LO = 12;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic ar_ld_pc;
    logic ar_ld_ir;
    logic ar_ld_dr;
    logic ir_ld;
    logic pc_inc;
    logic pc_ld;
    logic acc_ld;
    logic dr_inc;
    logic rr_en;
  } ctl_t;

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Sequencer <-> datapath/memory bundle. master = sequencer, slave = datapath side.
interface mc_seq_ctrl_if;
  logic        start;
  logic [15:0] ir;
  logic        mem_ack;
  logic        dr_zero;
  logic        skip_cond;

  logic [3:0]  sc;
  logic        run;
  logic        fault;
  logic        mem_rd;
  logic        mem_wr;
  logic        ar_ld_pc;
  logic        ar_ld_ir;
  logic        ar_ld_dr;
  logic        ir_ld;
  logic        pc_inc;
  logic        pc_ld;
  logic        acc_ld;
  logic        dr_inc;
  logic        rr_en;
  logic [2:0]  alu_op;

  modport master (
    input  start, ir, mem_ack, dr_zero, skip_cond,
    output sc, run, fault, mem_rd, mem_wr, ar_ld_pc, ar_ld_ir, ar_ld_dr,
           ir_ld, pc_inc, pc_ld, acc_ld, dr_inc, rr_en, alu_op
  );

  modport slave (
    output start, ir, mem_ack, dr_zero, skip_cond,
    input  sc, run, fault, mem_rd, mem_wr, ar_ld_pc, ar_ld_ir, ar_ld_dr,
           ir_ld, pc_inc, pc_ld, acc_ld, dr_inc, rr_en, alu_op
  );
endinterface

// File: rtl/mc_seq_ctrl_stall_timer.sv
// Counts consecutive cycles a memory strobe waits for ack; flags the cycle
// on which the wait would reach STALL_LIMIT.
module mc_stall_timer #(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic expire_o
);
  localparam int W = $clog2(STALL_LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = wait_i ? cnt_q + W'(1) : '0;
    expire_o = wait_i && (cnt_q == W'(STALL_LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mc_seq_ctrl.sv
// Multicycle control sequencer: owns the step counter feeding the external
// 4-to-16 timing decoder and emits per-step datapath/memory strobes.
module mc_seq_ctrl
  import mc_pkg::*;
#(
  parameter int STALL_LIMIT = 255,
  parameter int HLT_BIT     = 0
) (
  input  logic          clk,
  input  logic          rst,
  mc_seq_ctrl_if.master bus
);
  state_e     state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] opc_q, opc_d;
  logic       ind_q, ind_d;
  logic       fault_q, fault_d;

  ctl_t       ctl;
  logic [2:0] alu_op;
  logic       last, halt, mem_wait, timeout;

  mc_stall_timer #(.STALL_LIMIT(STALL_LIMIT)) u_stall (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (mem_wait),
    .expire_o (timeout)
  );

  always_comb begin
    ctl      = '0;
    alu_op   = '0;
    last     = 1'b0;
    halt     = 1'b0;
    opc_d    = opc_q;
    ind_d    = ind_q;
    state_d  = state_q;
    sc_d     = sc_q;
    fault_d  = fault_q;

    if (state_q == RUN) begin
      case (sc_q)
        T0: ctl.ar_ld_pc = 1'b1;
        T1: begin
          ctl.mem_rd = 1'b1;
          ctl.ir_ld  = bus.mem_ack;
          ctl.pc_inc = bus.mem_ack;
        end
        T2: begin
          ctl.ar_ld_ir = 1'b1;
          opc_d        = bus.ir[IR_OP_HI:IR_OP_LO];
          ind_d        = bus.ir[IR_I];
        end
        T3: begin
          if (opc_q == OP_RRF) begin
            ctl.rr_en  = 1'b1;
            ctl.pc_inc = bus.skip_cond;
            last       = 1'b1;
            halt       = bus.ir[HLT_BIT];
          end else if (ind_q) begin
            ctl.mem_rd   = 1'b1;
            ctl.ar_ld_dr = bus.mem_ack;
          end
        end
        T4: begin
          case (opc_q)
            OP_AND, OP_ADD, OP_LDA: ctl.mem_rd = 1'b1;
            OP_STA: begin ctl.mem_wr = 1'b1; last = 1'b1; end
            OP_BUN: begin ctl.pc_ld  = 1'b1; last = 1'b1; end
            OP_BSA: ctl.mem_wr = 1'b1;
            OP_ISZ: ctl.mem_rd = 1'b1;
            default: last = 1'b1;
          endcase
        end
        T5: begin
          case (opc_q)
            OP_AND, OP_ADD, OP_LDA: begin
              ctl.acc_ld = 1'b1;
              alu_op     = opc_q;
              last       = 1'b1;
            end
            OP_BSA: begin ctl.pc_ld = 1'b1; ctl.pc_inc = 1'b1; last = 1'b1; end
            OP_ISZ: ctl.dr_inc = 1'b1;
            default: last = 1'b1;
          endcase
        end
        T6: begin
          if (opc_q == OP_ISZ) begin
            ctl.mem_wr = 1'b1;
            ctl.pc_inc = bus.mem_ack & bus.dr_zero;
          end
          last = 1'b1;
        end
        default: ;
      endcase
    end

    // Step holds while a strobe waits; a terminal memory step also waits.
    mem_wait = (ctl.mem_rd | ctl.mem_wr) & ~bus.mem_ack;

    case (state_q)
      IDLE: begin
        if (bus.start && !fault_q) begin
          state_d = RUN;
          sc_d    = T0;
        end
      end
      RUN: begin
        if (timeout || sc_q == T_ILL) begin
          fault_d = 1'b1;
          state_d = IDLE;
          sc_d    = T0;
        end else if (!mem_wait) begin
          if (last) begin
            sc_d = T0;
            if (halt) state_d = IDLE;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= T0;
      opc_q   <= '0;
      ind_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      opc_q   <= opc_d;
      ind_q   <= ind_d;
      fault_q <= fault_d;
    end
  end

  assign bus.sc       = sc_q;
  assign bus.run      = (state_q == RUN);
  assign bus.fault    = fault_q;
  assign bus.mem_rd   = ctl.mem_rd;
  assign bus.mem_wr   = ctl.mem_wr;
  assign bus.ar_ld_pc = ctl.ar_ld_pc;
  assign bus.ar_ld_ir = ctl.ar_ld_ir;
  assign bus.ar_ld_dr = ctl.ar_ld_dr;
  assign bus.ir_ld    = ctl.ir_ld;
  assign bus.pc_inc   = ctl.pc_inc;
  assign bus.pc_ld    = ctl.pc_ld;
  assign bus.acc_ld   = ctl.acc_ld;
  assign bus.dr_inc   = ctl.dr_inc;
  assign bus.rr_en    = ctl.rr_en;
  assign bus.alu_op   = alu_op;
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: each instruction is expanded into its
// expected step list from the opcode table, then replayed with random ack delays.
module tb_mc_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_seq_ctrl_if bus();

  mc_seq_ctrl #(.STALL_LIMIT(4), .HLT_BIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [10:0] S_RD    = 11'h400;
  localparam logic [10:0] S_WR    = 11'h200;
  localparam logic [10:0] S_ARPC  = 11'h100;
  localparam logic [10:0] S_ARIR  = 11'h080;
  localparam logic [10:0] S_ARDR  = 11'h040;
  localparam logic [10:0] S_IRLD  = 11'h020;
  localparam logic [10:0] S_PCINC = 11'h010;
  localparam logic [10:0] S_PCLD  = 11'h008;
  localparam logic [10:0] S_ACC   = 11'h004;
  localparam logic [10:0] S_DRINC = 11'h002;
  localparam logic [10:0] S_RR    = 11'h001;

  typedef struct {
    int          sc;
    logic [10:0] base;
    logic [10:0] on_ack;
    bit          mem;
    bit          skip_pc;
    bit          dz_pc;
    logic [2:0]  alu;
  } step_t;

  step_t       plan[$];
  logic [15:0] ir_nx = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [10:0] strb();
    return {bus.mem_rd, bus.mem_wr, bus.ar_ld_pc, bus.ar_ld_ir, bus.ar_ld_dr,
            bus.ir_ld, bus.pc_inc, bus.pc_ld, bus.acc_ld, bus.dr_inc, bus.rr_en};
  endfunction

  function automatic void push(input int sc, input logic [10:0] base, input logic [10:0] on_ack,
                               input bit skip_pc, input bit dz_pc, input logic [2:0] alu);
    step_t s;
    s.sc = sc; s.base = base; s.on_ack = on_ack;
    s.mem = |(base & (S_RD | S_WR));
    s.skip_pc = skip_pc; s.dz_pc = dz_pc; s.alu = alu;
    plan.push_back(s);
  endfunction

  // Expected step list straight from the instruction table.
  function automatic void build(input logic [15:0] irv);
    logic [2:0] opc;
    logic       ind;
    opc = irv[14:12];
    ind = irv[15];
    plan.delete();
    push(0, S_ARPC, '0, 0, 0, 3'd0);
    push(1, S_RD, S_IRLD | S_PCINC, 0, 0, 3'd0);
    push(2, S_ARIR, '0, 0, 0, 3'd0);
    if (opc == 3'd7) begin
      push(3, S_RR, '0, 1, 0, 3'd0);
    end else begin
      push(3, ind ? S_RD : 11'h0, ind ? S_ARDR : 11'h0, 0, 0, 3'd0);
      case (opc)
        3'd0, 3'd1, 3'd2: begin push(4, S_RD, '0, 0, 0, 3'd0); push(5, S_ACC, '0, 0, 0, opc); end
        3'd3: push(4, S_WR, '0, 0, 0, 3'd0);
        3'd4: push(4, S_PCLD, '0, 0, 0, 3'd0);
        3'd5: begin push(4, S_WR, '0, 0, 0, 3'd0); push(5, S_PCLD | S_PCINC, '0, 0, 0, 3'd0); end
        default: begin
          push(4, S_RD, '0, 0, 0, 3'd0);
          push(5, S_DRINC, '0, 0, 0, 3'd0);
          push(6, S_WR, '0, 0, 1, 3'd0);
        end
      endcase
    end
  endfunction

  task automatic cyc(input logic a, input logic sk, input logic dz);
    @(negedge clk);
    bus.ir        = ir_nx;
    bus.mem_ack   = a;
    bus.skip_cond = sk;
    bus.dr_zero   = dz;
    bus.start     = 1'b0;
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic fexp);
    chk({tag, ".sc"}, 32'(bus.sc), 32'd0);
    chk({tag, ".run"}, 32'(bus.run), 32'd0);
    chk({tag, ".fault"}, 32'(bus.fault), 32'(fexp));
    chk({tag, ".strobes"}, 32'(strb()), 32'd0);
    chk({tag, ".alu_op"}, 32'(bus.alu_op), 32'd0);
  endtask

  // dly<0: random ack delay 0..3 per memory step, random ack on non-memory
  // steps, random start pulses while running. dzv<0: random dr_zero.
  task automatic run_instr(input logic [15:0] irv, input int dly, input int dzv, output int ncyc);
    build(irv);
    ir_nx = irv;
    ncyc  = 0;
    foreach (plan[i]) begin
      int d;
      d = plan[i].mem ? ((dly < 0) ? int'($urandom_range(3, 0)) : dly) : 0;
      for (int k = 0; k <= d; k++) begin
        logic a, sk, dz;
        logic [10:0] e;
        a  = plan[i].mem ? (k == d) : ((dly < 0) ? 1'($urandom_range(1, 0)) : 1'b0);
        sk = 1'($urandom_range(1, 0));
        dz = (dzv < 0) ? 1'($urandom_range(1, 0)) : dzv[0];
        cyc(a, sk, dz);
        ncyc++;
        e = plan[i].base;
        if (plan[i].mem && a)     e |= plan[i].on_ack;
        if (plan[i].skip_pc && sk) e |= S_PCINC;
        if (plan[i].dz_pc && a && dz) e |= S_PCINC;
        chk("sc", 32'(bus.sc), 32'(plan[i].sc));
        chk("run", 32'(bus.run), 32'd1);
        chk("strobes", 32'(strb()), 32'(e));
        chk("alu_op", 32'(bus.alu_op), 32'(plan[i].alu));
        if (dly < 0) bus.start = 1'($urandom_range(1, 0));
      end
    end
  endtask

  initial begin
    int n;
    logic [15:0] irv;
    bus.start = 1'b0; bus.ir = '0; bus.mem_ack = 1'b0;
    bus.dr_zero = 1'b0; bus.skip_cond = 1'b0;

    // Reset, then idle without start
    rst = 1'b1;
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk_idle("reset", 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom_range(1, 0)), 0, 0);
      chk_idle("idle_no_start", 1'b0);
    end

    // Directed instructions
    bus.start = 1'b1;
    run_instr(16'h2005, 0, 0, n); chk("lda_len", 32'(n), 32'd6);
    run_instr(16'h9010, 3, 0, n); chk("add_ind_len", 32'(n), 32'd15);
    run_instr(16'h6020, 0, 1, n); chk("isz_len", 32'(n), 32'd7);
    run_instr(16'h7001, 0, 0, n); chk("hlt_len", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk_idle("halted", 1'b0);
    end

    // Random instruction stream; resumes at T0 after each HLT
    bus.start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      irv = 16'($urandom);
      run_instr(irv, -1, -1, n);
      if (irv[14:12] == 3'd7 && irv[0]) begin
        cyc(0, 0, 0);
        chk_idle("rand_halt", 1'b0);
        bus.start = 1'b1;
      end
    end
    run_instr(16'h7001, -1, -1, n);
    cyc(0, 0, 0);
    chk_idle("rand_end", 1'b0);

    // Stall timeout at T1
    bus.start = 1'b1;
    ir_nx = 16'h2005;
    cyc(0, 0, 0);
    chk("to_t0_sc", 32'(bus.sc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0);
      chk("to_stall_sc", 32'(bus.sc), 32'd1);
      chk("to_stall_strobes", 32'(strb()), 32'(S_RD));
      chk("to_stall_fault", 32'(bus.fault), 32'd0);
    end
    cyc(0, 0, 0);
    chk_idle("timeout", 1'b1);
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk_idle("fault_start_ignored", 1'b1);
    end
    rst = 1'b1;
    cyc(0, 0, 0);
    chk_idle("fault_rst", 1'b0);
    rst = 1'b0;

    // Reset in the middle of STA T4
    bus.start = 1'b1;
    ir_nx = 16'h3000;
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("sta_t4_sc", 32'(bus.sc), 32'd4);
    chk("sta_t4_strobes", 32'(strb()), 32'(S_WR));
    rst = 1'b1;
    cyc(0, 0, 0);
    chk_idle("sta_rst", 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk_idle("after_rst", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
Multicycle control sequencer. It owns the 4-bit step counter that drives the 4-to-16 timing decoder. It decodes the opcode and indirect bit held in the IR and emits per-step control strobes for AR/PC/IR/ACC/DR/memory. Memory accesses use a req/ack handshake, and the step counter stalls until the ack arrives.

Parameters:
STALL_LIMIT, 255, max cycles a memory strobe may wait for mem_ack before fault
HLT_BIT, 0, IR bit index that marks HLT in a register-reference instruction (opcode 7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; leaves halted state
ir  in  16  current IR contents; [15]=I (indirect), [14:12]=opcode
mem_ack  in  1  memory completed the current mem_rd/mem_wr
dr_zero  in  1  DR==0 after increment (ISZ skip)
skip_cond  in  1  register-reference skip condition true
sc  out  4  step count; sc[3] is the decoder MSB
run  out  1  1 while sequencing
fault  out  1  sticky; set on stall timeout
mem_rd, mem_wr  out  1  memory strobes, held until mem_ack
ar_ld_pc, ar_ld_ir, ar_ld_dr  out  1  AR load source select, one-hot or none
ir_ld, pc_inc, pc_ld  out  1  register strobes
acc_ld, dr_inc, rr_en  out  1  ACC load, DR increment, register-ref execute
alu_op  out  3  equals latched opcode during acc_ld, else 0

Behaviour:
- Reset: sc=0, run=0, fault=0, opc/ind regs=0, stall counter=0. All strobes and alu_op are 0.
- States are IDLE and RUN. IDLE→RUN on start with fault=0, and sc=0 on entry. RUN→IDLE on HLT or fault. start is ignored while run=1.
- Strobes are combinational from (state, sc, opc, ind, inputs) and are 0 in IDLE.
- sc advances by 1 each RUN cycle, with two exceptions:
  - It holds while mem_rd or mem_wr is high and mem_ack=0.
  - It clears to 0 on the last step of each instruction. A terminal step that carries a memory strobe also waits for mem_ack.
- Steps in every instruction:
  - T0: ar_ld_pc.
  - T1: mem_rd; on the ack cycle, ir_ld and pc_inc.
  - T2: ar_ld_ir; latch opc=ir[14:12], ind=ir[15].
  - T3, opc≠7 and ind=1: mem_rd; on ack, ar_ld_dr.
  - T3, opc≠7 and ind=0: idle step.
  - T3, opc=7: rr_en; pc_inc if skip_cond. If ir[HLT_BIT]=1, go to IDLE with sc=0; otherwise clear.
- Execute steps from T4, one line per opcode:
  - AND(0)/ADD(1)/LDA(2): T4 mem_rd; T5 acc_ld with alu_op=opc, clear.
  - STA(3): T4 mem_wr, clear on ack.
  - BUN(4): T4 pc_ld, clear.
  - BSA(5): T4 mem_wr; T5 pc_ld and pc_inc, clear.
  - ISZ(6): T4 mem_rd; T5 dr_inc; T6 mem_wr, with pc_inc on the ack cycle if dr_zero; clear.
- sc never exceeds 6 in legal operation. Reaching 15 is treated as a fault, same as a timeout.
- Stall counter:
  - Increments each cycle a memory strobe is high without mem_ack, and resets to 0 on ack.
  - When it reaches STALL_LIMIT: fault=1, go to IDLE, sc=0.
  - fault clears only on rst.
- Simultaneous events:
  - mem_ack arriving the same cycle a strobe first rises is a zero-wait access; the step completes that cycle.
  - mem_ack with no strobe high is ignored.
- rst mid-instruction aborts immediately. The next edge after rst deassertion leaves all strobes 0, and a start is required to resume.

Decomposition:
- Package mc_pkg holds:
  - opcode constants OP_AND..OP_RRF (0..7);
  - step constants T0..T6;
  - the state enum {IDLE,RUN};
  - the IR field positions.
- Sub-module mc_stall_timer (counter plus limit compare) is natural.
- The decoder itself stays external: sc drives the 4-to-16 decoder inputs, sc[3]→MSB.

Test Plan:
1. rst high 2 cycles, then low without start → run=0, sc=0, all strobes 0 for 10 cycles.
2. start; ir=16'h2005 (LDA, direct); mem_ack returned the same cycle as each strobe.
   - Strobe sequence: T0 ar_ld_pc; T1 mem_rd/ir_ld/pc_inc; T2 ar_ld_ir; T3 none; T4 mem_rd; T5 acc_ld with alu_op=2.
   - sc then returns to 0.
3. ir=16'h9010 (ADD, indirect); mem_ack delayed 3 cycles on each read.
   - sc holds at 1, 3 and 4 for 3 cycles each; ar_ld_dr pulses once at T3.
   - Total instruction length is 6+9=15 cycles.
4. ir=16'h6020 (ISZ) with dr_zero=1 at T6 → dr_inc at T5; mem_wr and pc_inc at T6; sc→0.
5. ir=16'h7001 (HLT) → rr_en at T3, then run=0, sc=0. A later start resumes at T0.
6. Fault and reset cases:
   - STALL_LIMIT=4, mem_ack held 0 at T1 → fault=1 after 4 stall cycles; run=0; start ignored.
   - rst asserted mid-T4 of an STA → next cycle all outputs are at their reset values.
